ex_stage: RTL and testbench

Execute stage of the five-stage pipeline. It sits between the ID/EX pipeline register and the MEM stage, and registers its results into the EX/MEM boundary. Single-cycle ALU, shift, branch and jump resolution complete in one cycle. MULT/MULTU/DIV/DIVU run on an iterative 32-cycle unit that writes HI/LO and stalls the upstream stages while busy.

---
 rtl/ex_pkg.sv | 37 +++
 rtl/ex_muldiv.sv | 110 +++++++++++
 rtl/ex_stage.sv | 129 ++++++++++++
 tb/tb_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - opcodes, widths and mul/div state encoding shared by the execute stage
package ex_pkg;

    localparam int XLEN = 32;

    typedef enum logic [5:0] {
        OP_ADD   = 6'h00,
        OP_SUB   = 6'h01,
        OP_AND   = 6'h02,
        OP_OR    = 6'h03,
        OP_XOR   = 6'h04,
        OP_NOR   = 6'h05,
        OP_SLT   = 6'h06,
        OP_SLTU  = 6'h07,
        OP_SLL   = 6'h08,
        OP_SRL   = 6'h09,
        OP_SRA   = 6'h0A,
        OP_LUI   = 6'h0B,
        OP_MULT  = 6'h10,
        OP_MULTU = 6'h11,
        OP_DIV   = 6'h12,
        OP_DIVU  = 6'h13,
        OP_MFHI  = 6'h14,
        OP_MFLO  = 6'h15
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative 32-step multiply/divide unit with HI/LO, built only under EX_MULDIV_EN
`ifdef EX_MULDIV_EN
module ex_muldiv
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [5:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_t   state, state_next;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] divisor;
    logic [31:0] dividend;
    logic        is_div, neg_res, neg_rem, div_zero;
    logic        start, is_signed;
    logic [31:0] mag_a, mag_b, quo, rem;
    logic [32:0] mul_sum, div_trial, div_diff;
    logic [63:0] acc_step, product;

    assign is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign mag_a     = (is_signed && op_a[31]) ? -op_a : op_a;
    assign mag_b     = (is_signed && op_b[31]) ? -op_b : op_b;
    assign start     = (state == MD_IDLE) && in_valid && is_muldiv(alu_op) && !flush;
    assign stall     = ((state == MD_IDLE) && in_valid && is_muldiv(alu_op)) || (state == MD_BUSY);
    assign done      = (state == MD_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = MD_BUSY;
            MD_BUSY: if (count == 5'd0) state_next = MD_DONE;
            default: state_next = MD_IDLE;
        endcase
        if (flush) state_next = MD_IDLE;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
    assign div_trial = {acc[63:32], acc[31]};
    assign div_diff  = div_trial - {1'b0, divisor};

    always_comb begin
        acc_step = {mul_sum, acc[31:1]};
        if (is_div) begin
            acc_step = div_diff[32] ? {div_trial[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0], acc[30:0], 1'b1};
        end
    end

    assign product = neg_res ? -acc : acc;
    assign quo     = neg_res ? -acc[31:0] : acc[31:0];
    assign rem     = neg_rem ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            acc      <= '0;
            divisor  <= '0;
            dividend <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            count    <= 5'd31;
            acc      <= {32'd0, mag_a};
            divisor  <= mag_b;
            dividend <= op_a;
            is_div   <= (alu_op == OP_DIV) || (alu_op == OP_DIVU);
            neg_res  <= is_signed && (op_a[31] ^ op_b[31]);
            neg_rem  <= is_signed && op_a[31];
            div_zero <= (op_b == '0);
        end else if (state == MD_BUSY) begin
            acc   <= acc_step;
            count <= count - 5'd1;
        end else if ((state == MD_DONE) && !flush) begin
            if (is_div && div_zero) begin
                lo <= '1;
                hi <= dividend;
            end else if (is_div) begin
                lo <= quo;
                hi <= rem;
            end else begin
                {hi, lo} <= product;
            end
        end
    end

endmodule
`endif

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch resolution, EX/MEM register; mul/div under EX_MULDIV_EN
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [5:0]      alu_op,
    input  logic            alu_src,
    input  logic            reg_dst,
    input  logic            branch,
    input  logic            jump,
    input  logic            write_signal,
    input  logic            mem_to_reg,
    input  logic            reg_write,
    input  logic            is_mem_inst,
    input  logic            is_word,
    input  logic            halted,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] read_data_1,
    input  logic [XLEN-1:0] read_data_2,
    input  logic [XLEN-1:0] sign_extend_out,
    input  logic [4:0]      instruction_20_to_16,
    input  logic [4:0]      instruction_15_to_11,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] write_data,
    output logic [4:0]      dest_reg,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            write_signal_out,
    output logic            mem_to_reg_out,
    output logic            reg_write_out,
    output logic            is_mem_inst_out,
    output logic            is_word_out,
    output logic            halted_out
);

    alu_op_t         op;
    logic [XLEN-1:0] opa, opb, result, hi, lo, target_next;
    logic [4:0]      shamt;
    logic            md_hold, md_done, taken_next;

    assign op    = alu_op_t'(alu_op);
    assign opa   = read_data_1;
    assign opb   = alu_src ? sign_extend_out : read_data_2;
    assign shamt = sign_extend_out[10:6];

`ifdef EX_MULDIV_EN
    ex_muldiv u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .flush    (flush),
        .alu_op   (alu_op),
        .op_a     (opa),
        .op_b     (opb),
        .stall    (stall),
        .done     (md_done),
        .hi       (hi),
        .lo       (lo)
    );
    // mul/div retires from DONE, not from the accept cycle
    assign md_hold = is_muldiv(alu_op);
`else
    assign stall   = 1'b0;
    assign md_done = 1'b0;
    assign md_hold = 1'b0;
    assign hi      = '0;
    assign lo      = '0;
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = opa + opb;
            OP_SUB:  result = opa - opb;
            OP_AND:  result = opa & opb;
            OP_OR:   result = opa | opb;
            OP_XOR:  result = opa ^ opb;
            OP_NOR:  result = ~(opa | opb);
            OP_SLT:  result = {31'd0, $signed(opa) < $signed(opb)};
            OP_SLTU: result = {31'd0, opa < opb};
            OP_SLL:  result = opb << shamt;
            OP_SRL:  result = opb >> shamt;
            OP_SRA:  result = $signed(opb) >>> shamt;
            OP_LUI:  result = {opb[15:0], 16'h0};
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    assign taken_next  = in_valid && ((branch && (opa == opb)) || jump);
    assign target_next = jump ? opa : pc + (sign_extend_out << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            alu_result       <= '0;
            write_data       <= '0;
            dest_reg         <= '0;
            branch_taken     <= 1'b0;
            branch_target    <= '0;
            write_signal_out <= 1'b0;
            mem_to_reg_out   <= 1'b0;
            reg_write_out    <= 1'b0;
            is_mem_inst_out  <= 1'b0;
            is_word_out      <= 1'b0;
            halted_out       <= 1'b0;
        end else begin
            out_valid        <= !flush && (md_done || (in_valid && !md_hold));
            branch_taken     <= !flush && taken_next;
            alu_result       <= result;
            write_data       <= read_data_2;
            dest_reg         <= reg_dst ? instruction_15_to_11 : instruction_20_to_16;
            branch_target    <= target_next;
            write_signal_out <= write_signal;
            mem_to_reg_out   <= mem_to_reg;
            reg_write_out    <= reg_write && !is_muldiv(alu_op);
            is_mem_inst_out  <= is_mem_inst;
            is_word_out      <= is_word;
            halted_out       <= halted;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage; mul/div scenarios follow EX_MULDIV_EN
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, alu_src, reg_dst, branch, jump;
    logic        write_signal, mem_to_reg, reg_write, is_mem_inst, is_word, halted;
    logic [5:0]  alu_op;
    logic [31:0] pc, read_data_1, read_data_2, sign_extend_out;
    logic [4:0]  instruction_20_to_16, instruction_15_to_11;
    logic        stall, out_valid, branch_taken;
    logic [31:0] alu_result, write_data, branch_target;
    logic [4:0]  dest_reg;
    logic        write_signal_out, mem_to_reg_out, reg_write_out, is_mem_inst_out, is_word_out, halted_out;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch), .jump(jump),
        .write_signal(write_signal), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .is_mem_inst(is_mem_inst), .is_word(is_word), .halted(halted), .pc(pc),
        .read_data_1(read_data_1), .read_data_2(read_data_2), .sign_extend_out(sign_extend_out),
        .instruction_20_to_16(instruction_20_to_16), .instruction_15_to_11(instruction_15_to_11),
        .stall(stall), .out_valid(out_valid), .alu_result(alu_result), .write_data(write_data),
        .dest_reg(dest_reg), .branch_taken(branch_taken), .branch_target(branch_target),
        .write_signal_out(write_signal_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out(reg_write_out), .is_mem_inst_out(is_mem_inst_out),
        .is_word_out(is_word_out), .halted_out(halted_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [4:0]  dst;
        logic [31:0] wd;
        logic        rw;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    localparam int NALU = 13;
    logic [5:0]  t_op  [NALU] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR,
                                  OP_NOR, OP_SLL, OP_SRA, OP_SRL, OP_LUI, OP_ADD};
    logic [31:0] t_a   [NALU] = '{32'd7, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hFFFF0000, 32'h0000FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10};
    logic [31:0] t_b   [NALU] = '{32'd5, 32'd7, 32'd1, 32'd1, 32'hFF00FF00, 32'h0000FFFF,
                                  32'h0F0F0F0F, 32'h00FF0000, 32'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd3};
    logic [31:0] t_imm [NALU] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                  32'h100, 32'h100, 32'h100, 32'h1234, 32'hFFFFFFFF};
    logic        t_src [NALU] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [31:0] t_exp [NALU] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000F000, 32'hF0F0FFFF,
                                  32'hF0F00F0F, 32'hFF000000, 32'h10, 32'hF8000000, 32'h08000000,
                                  32'h12340000, 32'd9};

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src);
        in_valid = 1'b1; alu_op = op; read_data_1 = a; read_data_2 = b;
        sign_extend_out = imm; alu_src = src; branch = 1'b0; jump = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(OP_ADD, 32'd7, 32'd5, 32'd0, 1'b0);
        jump = 1'b1; reg_write = 1'b1; reg_dst = 1'b0; instruction_20_to_16 = 5'd3; pc = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%h want=0", out_valid); end
        checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL reset_alu_result got=%h want=0", alu_result); end
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch_taken got=%h want=0", branch_taken); end
        checks++; if (branch_target !== 32'd0) begin errors++; $display("FAIL reset_branch_target got=%h want=0", branch_target); end
        checks++; if (dest_reg !== 5'd0) begin errors++; $display("FAIL reset_dest_reg got=%h want=0", dest_reg); end
        checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL reset_reg_write_out got=%h want=0", reg_write_out); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%h want=0", stall); end
        rst = 1'b0; jump = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_alu;
        for (int i = 0; i < NALU; i++) begin
            drive(t_op[i], t_a[i], t_b[i], t_imm[i], t_src[i]);
            reg_dst = i[0]; instruction_20_to_16 = 5'(i); instruction_15_to_11 = 5'(i + 16);
            reg_write = 1'b1;
            e = '{valid: 1'b1, res: t_exp[i], dst: (i[0] ? 5'(i + 16) : 5'(i)), wd: t_b[i],
                  rw: 1'b1, taken: 1'b0, tgt: 32'd0};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (out_valid !== e.valid) begin errors++; $display("FAIL alu_out_valid[%0d] got=%h want=%h", i, out_valid, e.valid); end
            checks++; if (alu_result !== e.res) begin errors++; $display("FAIL alu_result[%0d] got=%h want=%h", i, alu_result, e.res); end
            checks++; if (dest_reg !== e.dst) begin errors++; $display("FAIL alu_dest_reg[%0d] got=%h want=%h", i, dest_reg, e.dst); end
            checks++; if (write_data !== e.wd) begin errors++; $display("FAIL alu_write_data[%0d] got=%h want=%h", i, write_data, e.wd); end
            checks++; if (reg_write_out !== e.rw) begin errors++; $display("FAIL alu_reg_write_out[%0d] got=%h want=%h", i, reg_write_out, e.rw); end
            checks++; if (branch_taken !== e.taken) begin errors++; $display("FAIL alu_branch_taken[%0d] got=%h want=%h", i, branch_taken, e.taken); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_branch;
        logic [31:0] b_a   [6] = '{32'd3, 32'd3, 32'd7, 32'h2000, 32'h2000, 32'h3000};
        logic [31:0] b_b   [6] = '{32'd3, 32'd4, 32'd7, 32'd0, 32'd0, 32'd0};
        logic [31:0] b_pc  [6] = '{32'h100, 32'h100, 32'h200, 32'h300, 32'h300, 32'h300};
        logic [31:0] b_imm [6] = '{32'd4, 32'd4, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd0};
        logic        b_br  [6] = '{1, 1, 1, 0, 0, 0};
        logic        b_j   [6] = '{0, 0, 0, 1, 1, 1};
        logic        b_v   [6] = '{1, 1, 1, 1, 0, 1};
        logic        b_fl  [6] = '{0, 0, 0, 0, 0, 1};
        logic        b_tk  [6] = '{1, 0, 1, 1, 0, 0};
        logic [31:0] b_tgt [6] = '{32'h110, 32'h110, 32'h1F8, 32'h2000, 32'h2000, 32'h3000};
        for (int i = 0; i < 6; i++) begin
            drive(OP_SUB, b_a[i], b_b[i], b_imm[i], 1'b0);
            branch = b_br[i]; jump = b_j[i]; in_valid = b_v[i]; flush = b_fl[i];
            pc = b_pc[i]; reg_write = 1'b0;
            e = '{valid: b_v[i] & ~b_fl[i], res: 32'd0, dst: 5'd0, wd: 32'd0, rw: 1'b0,
                  taken: b_tk[i], tgt: b_tgt[i]};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (out_valid !== e.valid) begin errors++; $display("FAIL br_out_valid[%0d] got=%h want=%h", i, out_valid, e.valid); end
            checks++; if (branch_taken !== e.taken) begin errors++; $display("FAIL br_taken[%0d] got=%h want=%h", i, branch_taken, e.taken); end
            if (e.taken) begin
                checks++; if (branch_target !== e.tgt) begin errors++; $display("FAIL br_target[%0d] got=%h want=%h", i, branch_target, e.tgt); end
            end
        end
        in_valid = 1'b0; flush = 1'b0; branch = 1'b0; jump = 1'b0;
    endtask

`ifdef EX_MULDIV_EN
    task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        drive(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0); reg_write = 1'b1;
        e = '{valid: 1'b1, res: exp_lo, dst: 5'd0, wd: 32'd0, rw: 1'b1, taken: 1'b0, tgt: 32'd0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (alu_result !== e.res) begin errors++; $display("FAIL %s_lo got=%h want=%h", name, alu_result, e.res); end
        drive(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);
        e.res = exp_hi;
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (alu_result !== e.res) begin errors++; $display("FAIL %s_hi got=%h want=%h", name, alu_result, e.res); end
        in_valid = 1'b0;
    endtask

    task automatic test_muldiv(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int   n;
        logic bubble_bad;
        drive(op, a, b, 32'd0, 1'b0); reg_write = 1'b1;
        e = '{valid: 1'b1, res: 32'd0, dst: 5'd0, wd: 32'd0, rw: 1'b0, taken: 1'b0, tgt: 32'd0};
        exp_q.push_back(e);
        #1;
        n = 0; bubble_bad = 1'b0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
            if (out_valid !== 1'b0) bubble_bad = 1'b1;
        end
        checks++; if (n != 33) begin errors++; $display("FAIL %s_stall_cycles got=%0d want=33", name, n); end
        checks++; if (bubble_bad !== 1'b0) begin errors++; $display("FAIL %s_bubble got=%h want=0", name, bubble_bad); end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (out_valid !== e.valid) begin errors++; $display("FAIL %s_done_valid got=%h want=%h", name, out_valid, e.valid); end
        checks++; if (reg_write_out !== e.rw) begin errors++; $display("FAIL %s_done_reg_write got=%h want=%h", name, reg_write_out, e.rw); end
        read_hilo(exp_hi, exp_lo, name);
    endtask

    task automatic test_flush;
        logic late_valid;
        drive(OP_DIVU, 32'd50, 32'd3, 32'd0, 1'b0);
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got=%h want=1", stall); end
        flush = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%h want=0", stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%h want=0", out_valid); end
        late_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || stall !== 1'b0) late_valid = 1'b1;
        end
        checks++; if (late_valid !== 1'b0) begin errors++; $display("FAIL flush_late_activity got=%h want=0", late_valid); end
        read_hilo(32'd9, 32'hFFFFFFFF, "flush");
    endtask
`else
    task automatic test_muldiv_nop;
        logic [5:0] ops [2] = '{OP_MULT, OP_DIV};
        for (int i = 0; i < 2; i++) begin
            drive(ops[i], 32'hFFFFFFFD, 32'd4, 32'd0, 1'b0); reg_write = 1'b1;
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nop_stall[%0d] got=%h want=0", i, stall); end
            e = '{valid: 1'b1, res: 32'd0, dst: 5'd0, wd: 32'd0, rw: 1'b0, taken: 1'b0, tgt: 32'd0};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (out_valid !== e.valid) begin errors++; $display("FAIL nop_out_valid[%0d] got=%h want=%h", i, out_valid, e.valid); end
            checks++; if (reg_write_out !== e.rw) begin errors++; $display("FAIL nop_reg_write[%0d] got=%h want=%h", i, reg_write_out, e.rw); end
        end
        drive(OP_MFHI, 32'd5, 32'd5, 32'd0, 1'b0);
        e = '{valid: 1'b1, res: 32'd0, dst: 5'd0, wd: 32'd0, rw: 1'b1, taken: 1'b0, tgt: 32'd0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (alu_result !== e.res) begin errors++; $display("FAIL nop_mfhi got=%h want=%h", alu_result, e.res); end
        drive(OP_MFLO, 32'd5, 32'd5, 32'd0, 1'b0);
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (alu_result !== e.res) begin errors++; $display("FAIL nop_mflo got=%h want=%h", alu_result, e.res); end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_op = 6'h00; alu_src = 1'b0; reg_dst = 1'b0;
        branch = 1'b0; jump = 1'b0; write_signal = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
        is_mem_inst = 1'b0; is_word = 1'b0; halted = 1'b0; pc = 32'd0; read_data_1 = 32'd0;
        read_data_2 = 32'd0; sign_extend_out = 32'd0; instruction_20_to_16 = 5'd0; instruction_15_to_11 = 5'd0;
        test_reset;
        test_alu;
        test_branch;
`ifdef EX_MULDIV_EN
        test_muldiv(OP_MULT,  32'hFFFFFFFD, 32'd4,       32'hFFFFFFFF, 32'hFFFFFFF4, "mult");
        test_muldiv(OP_MULTU, 32'hFFFFFFFF, 32'd2,       32'h00000001, 32'hFFFFFFFE, "multu");
        test_muldiv(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,       32'hFFFFFFFD, "div_pos_neg");
        test_muldiv(OP_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg_pos");
        test_muldiv(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,       32'h80000000, "div_ovf");
        test_muldiv(OP_DIVU,  32'd9,        32'd0,       32'd9,        32'hFFFFFFFF, "divu_zero");
        test_flush;
`else
        test_muldiv_nop;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
